// File: rtl/nova_qp_pkg.sv
// Shared QP constants, chroma QP mapping table and FSM state type for the QP delta encoder.
// The chroma table is only consumed when NOVA_QPC_OUTPUT_EN is defined.
package nova_qp_pkg;

  localparam logic [5:0]        QP_MAX      = 6'd51;
  localparam logic signed [6:0] QP_WRAP     = 7'sd52;
  localparam logic signed [6:0] DELTA_MIN   = -7'sd26;
  localparam logic signed [6:0] DELTA_MAX   = 7'sd25;
  localparam logic signed [6:0] QP_PIC_BASE = 7'sd26;

  // Chroma QP for luma-derived QPi in 30..51; below 30 chroma follows QPi directly.
  localparam logic [5:0] CHROMA_QP_TABLE [0:21] = '{
    6'd29, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33, 6'd34, 6'd34, 6'd35, 6'd35, 6'd36,
    6'd36, 6'd37, 6'd37, 6'd37, 6'd38, 6'd38, 6'd38, 6'd39, 6'd39, 6'd39, 6'd39
  };

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } qp_state_e;

  function automatic logic [5:0] clampQp(input logic [5:0] q);
    return (q > QP_MAX) ? QP_MAX : q;
  endfunction

  function automatic logic [2:0] floorLog2(input logic [6:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [5:0] chromaQp(input logic [5:0] qpi);
    logic [5:0] idx;
    if (qpi < 6'd30) return qpi;
    idx = qpi - 6'd30;
    return CHROMA_QP_TABLE[idx[4:0]];
  endfunction

endpackage

// File: rtl/se_golomb_serializer.sv
// Signed Exp-Golomb se(v) serializer: maps a 7-bit signed value to its code and
// shifts it out MSB first over a valid/ready bit stream.
module se_golomb_serializer
  import nova_qp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic signed [6:0] value_i,
  output logic              ready_o,
  output logic              bit_out_o,
  output logic              bit_valid_o,
  output logic              bit_last_o,
  input  logic              bit_ready_i
);

  qp_state_e   state_q, state_d;
  logic [12:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [6:0]  twoK;
  logic [6:0]  codeNum;
  logic [6:0]  codePlusOne;
  logic [2:0]  m;
  logic [12:0] codeAligned;

  // The code is M zeros followed by the M+1 bits of codeNum+1, so left-aligning
  // codeNum+1 inside a (2M+1)-bit window yields the whole bit string.
  always_comb begin
    twoK = {value_i[5:0], 1'b0};
    if (!value_i[6] && (value_i != 7'sd0)) codeNum = twoK - 7'd1;
    else                                   codeNum = 7'd0 - twoK;
    codePlusOne = codeNum + 7'd1;
    m           = floorLog2(codePlusOne);
    codeAligned = {6'b0, codePlusOne} << (4'd12 - {m, 1'b0});
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ready_o     = (state_q == IDLE);
    bit_valid_o = (state_q == SHIFT);
    bit_out_o   = (state_q == SHIFT) & shreg_q[12];
    bit_last_o  = (state_q == SHIFT) && (cnt_q == 4'd0);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SHIFT;
          shreg_d = codeAligned;
          cnt_d   = {m, 1'b0};
        end
      end
      SHIFT: begin
        if (bit_ready_i) begin
          if (cnt_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            shreg_d = {shreg_q[11:0], 1'b0};
            cnt_d   = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= 13'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/qp_delta_encoder.sv
// H.264 slice/macroblock QP delta encoder: tracks QPy, emits se(v) deltas as a bit stream.
// Define NOVA_QPC_OUTPUT_EN to add the registered chroma QP output QPc.
module qp_delta_encoder
  import nova_qp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              slice_valid,
  input  logic              mb_valid,
  output logic              in_ready,
  input  logic signed [5:0] pic_init_qp_minus26,
  input  logic [5:0]        slice_qp,
  input  logic [5:0]        mb_qp,
  input  logic              mb_qp_coded,
  input  logic signed [4:0] chroma_qp_index_offset,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_last,
  output logic [5:0]        QPy
`ifdef NOVA_QPC_OUTPUT_EN
  ,
  output logic [5:0]        QPc
`endif
);

  logic [5:0]        qpy_q, qpy_d;
  logic [5:0]        sliceQp, mbQp;
  logic              sliceAcc, mbAcc, serStart, serReady;
  logic signed [6:0] sliceDelta, mbDiff, mbDelta, serValue;

  // Slice requests win over a simultaneous macroblock request, which simply waits.
  always_comb begin
    sliceQp    = clampQp(slice_qp);
    mbQp       = clampQp(mb_qp);
    sliceAcc   = slice_valid & serReady;
    mbAcc      = mb_valid & serReady & ~slice_valid;
    sliceDelta = signed'({1'b0, sliceQp}) - QP_PIC_BASE - 7'(pic_init_qp_minus26);
    mbDiff     = signed'({1'b0, mbQp}) - signed'({1'b0, qpy_q});
    mbDelta    = mbDiff;
    if (mbDiff < DELTA_MIN)      mbDelta = mbDiff + QP_WRAP;
    else if (mbDiff > DELTA_MAX) mbDelta = mbDiff - QP_WRAP;
    serStart = sliceAcc | (mbAcc & mb_qp_coded);
    serValue = sliceAcc ? sliceDelta : mbDelta;
    qpy_d    = qpy_q;
    if (sliceAcc)                 qpy_d = sliceQp;
    else if (mbAcc & mb_qp_coded) qpy_d = mbQp;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) qpy_q <= 6'd0;
    else          qpy_q <= qpy_d;
  end

  assign QPy      = qpy_q;
  assign in_ready = serReady;

  se_golomb_serializer u_ser (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (serStart),
    .value_i     (serValue),
    .ready_o     (serReady),
    .bit_out_o   (bit_out),
    .bit_valid_o (bit_valid),
    .bit_last_o  (bit_last),
    .bit_ready_i (bit_ready)
  );

`ifdef NOVA_QPC_OUTPUT_EN
  logic [5:0]        qpc_q, qpc_d;
  logic signed [7:0] qpiSum;
  logic [5:0]        qpi;

  // Chroma QP lags QPy by one cycle since it is derived from the registered luma QP.
  always_comb begin
    qpiSum = signed'({2'b00, qpy_q}) + 8'(chroma_qp_index_offset);
    if (qpiSum < 8'sd0)                          qpi = 6'd0;
    else if (qpiSum > signed'({2'b00, QP_MAX}))  qpi = QP_MAX;
    else                                         qpi = qpiSum[5:0];
    qpc_d = chromaQp(qpi);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) qpc_q <= 6'd0;
    else          qpc_q <= qpc_d;
  end

  assign QPc = qpc_q;
`else
  logic unusedChromaOffset;
  assign unusedChromaOffset = ^chroma_qp_index_offset;
`endif

endmodule

// File: doc/qp_delta_encoder.md
QP_DELTA_ENCODER -- requirements
Module: qp_delta_encoder

Interface
REQ-001 SHALL have ports: clk input 1 clock; reset_n input 1 synchronous active-low reset.
REQ-002 SHALL have ports: slice_valid in 1, slice QP request; mb_valid in 1, macroblock QP request; in_ready out 1, accepts either request.
REQ-003 SHALL have ports: pic_init_qp_minus26 in 6 (signed); slice_qp in 6; mb_qp in 6; mb_qp_coded in 1, mb_qp_delta present in bitstream.
REQ-004 SHALL have ports: chroma_qp_index_offset in 5 (signed, -12..12).
REQ-005 SHALL have ports: bit_out out 1; bit_valid out 1; bit_ready in 1; bit_last out 1, final bit of the current se(v) code.
REQ-006 SHALL have ports: QPy out 6, current luma QP; QPc out 6, chroma QP (present only per REQ-020).

Function
REQ-007 SHALL implement FSM IDLE -> SHIFT -> IDLE; in_ready = 1 only in IDLE.
REQ-008 Slice accept (slice_valid & in_ready) SHALL compute slice_qp_delta = slice_qp - 26 - pic_init_qp_minus26 (7-bit signed), set QPy <= slice_qp next cycle, and enter SHIFT.
REQ-009 MB accept (mb_valid & in_ready & !slice_valid) with mb_qp_coded=1 SHALL compute d = mb_qp - QPy, then add 52 if d < -26 and subtract 52 if d > 25, set QPy <= mb_qp, and enter SHIFT.
REQ-010 MB accept with mb_qp_coded=0 SHALL emit no bits, leave QPy unchanged, and remain in IDLE.
REQ-011 slice_valid and mb_valid asserted together SHALL give the slice priority; the mb request waits.
REQ-012 slice_qp or mb_qp above 51 SHALL be clamped to 51 before use.
REQ-013 Signed value k SHALL map to codeNum = 2k-1 for k>0 and -2k for k<=0.
REQ-014 Code SHALL be Exp-Golomb: M = floor(log2(codeNum+1)) zeros, a 1, then the M LSBs of codeNum+1-2^M, MSB first, for 2M+1 bits total (max 13).
REQ-015 First bit_valid SHALL assert the cycle after accept; a bit advances only on bit_valid & bit_ready; bit_out/bit_last SHALL hold stable while bit_ready=0.
REQ-016 bit_last SHALL be 1 only with the final bit; its handshake SHALL return the FSM to IDLE next cycle (in_ready=1 that cycle).
REQ-017 QPc SHALL be registered from QPy one cycle later: QPi = clamp(QPy + chroma_qp_index_offset, 0, 51); QPc = QPi if QPi<30, else per H.264 Table 8-15 (30..51 -> 29,30,31,32,32,33,34,34,35,35,36,36,37,37,37,38,38,38,39,39,39,39).

Reset
REQ-018 reset_n=0 SHALL set FSM=IDLE, QPy=0, QPc=0, bit_valid=0, bit_out=0, and bit_last=0; in_ready SHALL read 1 the first cycle after release.
REQ-019 Reset mid-SHIFT SHALL abort the code with no further bits; bit_valid SHALL be 0 the next cycle.

Configuration
REQ-020 Macro NOVA_QPC_OUTPUT_EN defined SHALL compile in the QPc port and table; undefined SHALL remove the QPc port and logic, and chroma_qp_index_offset becomes unused with no other behavioural change.

Structure
REQ-021 Shared package nova_qp_pkg SHALL hold QP_MAX=51, QP_WRAP=52, the delta limits -26/25, the chroma QP table constant, and the FSM state typedef.
REQ-022 Sub-module se_golomb_serializer SHALL own REQ-013..REQ-016 (signed value in, bit stream out); the top owns the QP arithmetic, QPy/QPc, and arbitration.

Verification
REQ-023 pic_init_qp_minus26=0, slice_qp=28 -> delta 2, codeNum 3, bits 0,0,1,0,0 with bit_last on the 5th; QPy=28.
REQ-024 QPy=28, mb_qp=28, coded -> single bit 1 with bit_last=1; QPy stays 28.
REQ-025 Wrap: QPy=50, mb_qp=0 -> d=2, bits 00100. QPy=0, mb_qp=51 -> d=-1, codeNum 2, bits 011.
REQ-026 bit_ready held low 3 cycles on bit 2 of 00100 -> bit_out=0 stable, in_ready=0, no bit lost or duplicated.
REQ-027 QPc (macro on): QPy=40, offset 0 -> 36; QPy=40, offset -12 -> 28; QPy=45, offset +12 -> 39.
REQ-028 mb_qp_coded=0, mb_qp=10, QPy=30 -> no bit_valid, QPy=30, in_ready stays 1.
